pushbutton_updown: RTL and testbench

Parametrised successor to the single-button address stepper: two push-buttons (up, down) are synchronised, debounced in the system clock domain (no separate button clock), and step an ADDR_W-bit address register with wrap or saturate behaviour. Each accepted step emits a one-cycle `operation` strobe with direction, which downstream key/message-slot selection logic consumes. It sits between the board buttons and the RSA control FSM's slot/address selection.

---
 rtl/pb_nav_pkg.sv | 20 ++
 rtl/pb_debounce.sv | 57 +++++
 rtl/pushbutton_updown.sv | 202 ++++++++++++++++++++
 tb/tb_pushbutton_updown.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pb_nav_pkg.sv
// pb_nav_pkg
//   Shared types and defaults for the push-button address navigator:
//   the per-button hold FSM state encoding, the step direction constants
//   and the default debounce / auto-repeat timings.
package pb_nav_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } hold_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int DB_CYCLES_DEF  = 16;
  localparam int RPT_DELAY_DEF  = 50_000_000;
  localparam int RPT_PERIOD_DEF = 10_000_000;

endpackage

// File: rtl/pb_debounce.sv
// pb_debounce
//   Two-flop synchroniser, debounce counter and rising-edge pulse for one
//   raw push-button input. The debounced level flips only after the
//   synchronised input has disagreed with it for DB_CYCLES consecutive cycles.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous reset, active low
//   btn_raw  in   raw asynchronous button, active high
//   level    out  debounced button level
//   rise     out  one-cycle pulse on a 0->1 transition of level
module pb_debounce
  import pb_nav_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int              CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      level_q <= level;
      // any cycle of agreement restarts the stability window
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/pushbutton_updown.sv
// pushbutton_updown
//   Two debounced push-buttons step an ADDR_W-bit address up or down with
//   wrap (WRAP=1) or saturate (WRAP=0) at 0 and ADDR_MAX. Every real change
//   of the address is flagged by a one-cycle operation strobe with op_dir.
//   Optional feature macro: PB_AUTOREPEAT_EN (auto-repeat while held).
//
// Ports
//   clk        in   system clock (only clock)
//   rst        in   synchronous reset, active low
//   btn_up     in   raw up button, asynchronous, active high
//   btn_dn     in   raw down button, asynchronous, active high
//   address    out  current address
//   operation  out  one-cycle strobe, address changed this cycle
//   op_dir     out  direction of the last step (1 = up), held between steps
//   at_limit   out  address is 0 or ADDR_MAX
//
// Hold FSM (one per button)
//   state  | meaning
//   IDLE   | button released
//   HELD   | press accepted, waiting out the auto-repeat delay
//   REPEAT | auto-repeating every RPT_PERIOD cycles (PB_AUTOREPEAT_EN only)
module pushbutton_updown
  import pb_nav_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int ADDR_MAX   = 2**ADDR_W - 1,
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int WRAP       = 1,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_dn,
  output logic [ADDR_W-1:0] address,
  output logic              operation,
  output logic              op_dir,
  output logic              at_limit
);

  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(ADDR_MAX);

  if (ADDR_W < 2 || ADDR_W > 16) begin : g_bad_addr_w
    $error("pushbutton_updown: ADDR_W out of range");
  end
  if (ADDR_MAX < 1 || ADDR_MAX > 2**ADDR_W - 1) begin : g_bad_addr_max
    $error("pushbutton_updown: ADDR_MAX out of range");
  end
  if (DB_CYCLES < 2) begin : g_bad_db
    $error("pushbutton_updown: DB_CYCLES must be at least 2");
  end
  if (RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_rpt
    $error("pushbutton_updown: RPT_DELAY and RPT_PERIOD must be at least 1");
  end

  // index 0 = up channel, index 1 = down channel
  logic [1:0]  lvl;
  logic [1:0]  rise;
  hold_state_t hold_st [2];
  logic        req_up;
  logic        req_dn;

  pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_up),
    .level   (lvl[0]),
    .rise    (rise[0])
  );

  pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_dn),
    .level   (lvl[1]),
    .rise    (rise[1])
  );

`ifdef PB_AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt [2];
  logic [1:0]       rpt_req;

  // a repeat fires when the down-counter hits zero while still held; the
  // level term stops a stale repeat during the release debounce window
  always_comb begin
    rpt_req = '0;
    for (int i = 0; i < 2; i++) begin
      rpt_req[i] = (hold_st[i] != IDLE) && lvl[i] && (rpt_cnt[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        hold_st[i] <= IDLE;
        rpt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (hold_st[i])
          IDLE: begin
            if (rise[i]) begin
              hold_st[i] <= HELD;
              rpt_cnt[i] <= RPT_W'(RPT_DELAY - 1);
            end
          end
          HELD, REPEAT: begin
            if (!lvl[i]) begin
              hold_st[i] <= IDLE;
            end else if (rpt_cnt[i] == '0) begin
              hold_st[i] <= REPEAT;
              rpt_cnt[i] <= RPT_W'(RPT_PERIOD - 1);
            end else begin
              rpt_cnt[i] <= rpt_cnt[i] - 1'b1;
            end
          end
          default: hold_st[i] <= IDLE;
        endcase
      end
    end
  end

  assign req_up = rise[0] | rpt_req[0];
  assign req_dn = rise[1] | rpt_req[1];
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        hold_st[i] <= IDLE;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (hold_st[i])
          IDLE:    if (rise[i]) hold_st[i] <= HELD;
          HELD:    if (!lvl[i]) hold_st[i] <= IDLE;
          default: hold_st[i] <= IDLE;
        endcase
      end
    end
  end

  assign req_up = rise[0];
  assign req_dn = rise[1];
`endif

  // Requests in both directions in the same cycle cancel each other; this
  // also covers both channels repeating at once.
  logic              want_up;
  logic              want_dn;
  logic [ADDR_W-1:0] addr_nxt;
  logic              addr_chg;

  assign want_up = req_up & ~req_dn;
  assign want_dn = req_dn & ~req_up;

  always_comb begin
    addr_nxt = address;
    addr_chg = 1'b0;
    if (want_up) begin
      if (address == ADDR_TOP) begin
        if (WRAP != 0) begin
          addr_nxt = '0;
          addr_chg = 1'b1;
        end
      end else begin
        addr_nxt = address + 1'b1;
        addr_chg = 1'b1;
      end
    end else if (want_dn) begin
      if (address == '0) begin
        if (WRAP != 0) begin
          addr_nxt = ADDR_TOP;
          addr_chg = 1'b1;
        end
      end else begin
        addr_nxt = address - 1'b1;
        addr_chg = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      address   <= '0;
      operation <= 1'b0;
      op_dir    <= DIR_UP;
    end else begin
      operation <= addr_chg;
      if (addr_chg) begin
        address <= addr_nxt;
        op_dir  <= want_up ? DIR_UP : DIR_DN;
      end
    end
  end

  assign at_limit = (address == '0) || (address == ADDR_TOP);

endmodule

// File: tb/tb_pushbutton_updown.sv
// tb_pushbutton_updown
//   Drives one wrapping and one saturating instance from the same buttons.
//   Expected steps go into a queue per instance when a press is driven and
//   are popped when operation is seen; steady state is checked per vector.
module tb_pushbutton_updown;
  import pb_nav_pkg::*;

  localparam int AW = 4;
  localparam int DB = 4;
  localparam int LAT = DB + 2;
  localparam logic [AW-1:0] AMAX = 4'd15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic [AW-1:0] addr_w, addr_s;
  logic op_w, op_s, dir_w, dir_s, lim_w, lim_s;

  always #5 clk = ~clk;

  pushbutton_updown #(.ADDR_W(AW), .ADDR_MAX(15), .DB_CYCLES(DB), .WRAP(1),
                      .RPT_DELAY(20), .RPT_PERIOD(5)) dut_wrap (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
    .address(addr_w), .operation(op_w), .op_dir(dir_w), .at_limit(lim_w));

  pushbutton_updown #(.ADDR_W(AW), .ADDR_MAX(15), .DB_CYCLES(DB), .WRAP(0),
                      .RPT_DELAY(20), .RPT_PERIOD(5)) dut_sat (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
    .address(addr_s), .operation(op_s), .op_dir(dir_s), .at_limit(lim_s));

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          at;
    logic [AW-1:0] addr;
    logic        dir;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t e_w, e_s;
  always @(negedge clk) begin
    if (rst) begin
      if (op_w) begin
        if (q_w.size() == 0) begin
          check("wrap_unexpected_op", 32'(op_w), 0);
        end else begin
          e_w = q_w.pop_front();
          check("wrap_op_cycle", cyc, e_w.at);
          check("wrap_op_addr", 32'(addr_w), 32'(e_w.addr));
          check("wrap_op_dir", 32'(dir_w), 32'(e_w.dir));
        end
      end
      if (op_s) begin
        if (q_s.size() == 0) begin
          check("sat_unexpected_op", 32'(op_s), 0);
        end else begin
          e_s = q_s.pop_front();
          check("sat_op_cycle", cyc, e_s.at);
          check("sat_op_addr", 32'(addr_s), 32'(e_s.addr));
          check("sat_op_dir", 32'(dir_s), 32'(e_s.dir));
        end
      end
    end
  end

  // reference model for the hand-written sequences
  logic [AW-1:0] m_w, m_s;
  logic          md_w, md_s;

  function automatic logic [AW-1:0] nxt(logic [AW-1:0] a, bit up, bit wrap);
    if (up) return (a == AMAX) ? (wrap ? 4'd0 : a) : a + 4'd1;
    else    return (a == 4'd0) ? (wrap ? AMAX : a) : a - 4'd1;
  endfunction

  task automatic expect_step(int at, bit up);
    logic [AW-1:0] n;
    n = nxt(m_w, up, 1'b1);
    if (n != m_w) begin m_w = n; md_w = up; q_w.push_back('{at, n, up}); end
    n = nxt(m_s, up, 1'b0);
    if (n != m_s) begin m_s = n; md_s = up; q_s.push_back('{at, n, up}); end
  endtask

  task automatic check_state(string tag);
    check({tag, "_addr_w"}, 32'(addr_w), 32'(m_w));
    check({tag, "_dir_w"}, 32'(dir_w), 32'(md_w));
    check({tag, "_lim_w"}, 32'(lim_w), 32'(m_w == 0 || m_w == AMAX));
    check({tag, "_addr_s"}, 32'(addr_s), 32'(m_s));
    check({tag, "_dir_s"}, 32'(dir_s), 32'(md_s));
    check({tag, "_lim_s"}, 32'(lim_s), 32'(m_s == 0 || m_s == AMAX));
  endtask

  typedef struct {
    bit          up;
    bit          dn;
    int          hi;
    bit          op_w;
    logic [AW-1:0] a_w;
    bit          d_w;
    bit          op_s;
    logic [AW-1:0] a_s;
    bit          d_s;
  } vec_t;

  vec_t vecs[13];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    vecs[0]  = '{1, 0, 10, 1, 4'd1,  1, 1, 4'd1, 1};
    vecs[1]  = '{1, 0, 10, 1, 4'd2,  1, 1, 4'd2, 1};
    vecs[2]  = '{0, 1, 10, 1, 4'd1,  0, 1, 4'd1, 0};
    vecs[3]  = '{0, 1, 10, 1, 4'd0,  0, 1, 4'd0, 0};
    vecs[4]  = '{0, 1, 10, 1, 4'd15, 0, 0, 4'd0, 0};
    vecs[5]  = '{1, 0, 10, 1, 4'd0,  1, 1, 4'd1, 1};
    vecs[6]  = '{1, 0, 3,  0, 4'd0,  1, 0, 4'd1, 1};
    vecs[7]  = '{0, 1, 2,  0, 4'd0,  1, 0, 4'd1, 1};
    vecs[8]  = '{1, 1, 10, 0, 4'd0,  1, 0, 4'd1, 1};
    vecs[9]  = '{1, 0, 10, 1, 4'd1,  1, 1, 4'd2, 1};
    vecs[10] = '{0, 1, 10, 1, 4'd0,  0, 1, 4'd1, 0};
    vecs[11] = '{1, 0, 4,  1, 4'd1,  1, 1, 4'd2, 1};
    vecs[12] = '{0, 1, 3,  0, 4'd1,  1, 0, 4'd2, 1};

    // reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_w = 0; m_s = 0; md_w = 1; md_s = 1;
    check("rst_op_w", 32'(op_w), 0);
    check("rst_op_s", 32'(op_s), 0);
    check_state("rst");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // table vectors: raw held hi cycles, then 12 released cycles
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      btn_up = vecs[i].up;
      btn_dn = vecs[i].dn;
      k = cyc + 1;
      if (vecs[i].op_w) q_w.push_back('{k + LAT, vecs[i].a_w, vecs[i].d_w});
      if (vecs[i].op_s) q_s.push_back('{k + LAT, vecs[i].a_s, vecs[i].d_s});
      repeat (vecs[i].hi) @(posedge clk);
      #1;
      btn_up = 1'b0;
      btn_dn = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      m_w = vecs[i].a_w; md_w = vecs[i].d_w;
      m_s = vecs[i].a_s; md_s = vecs[i].d_s;
      check_state($sformatf("vec%0d", i));
    end

    // up held, down pressed while up still held: both step once
    @(posedge clk); #1;
    btn_up = 1'b1;
    k = cyc + 1;
    expect_step(k + LAT, 1'b1);
    repeat (8) @(posedge clk); #1;
    btn_dn = 1'b1;
    expect_step(cyc + 1 + LAT, 1'b0);
    repeat (8) @(posedge clk); #1;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (14) @(posedge clk); #1;
    check_state("held_then_dn");

    // reset in the middle of a hold: re-debounce from level 0, fresh step
    @(posedge clk); #1;
    btn_up = 1'b1;
    expect_step(cyc + 1 + LAT, 1'b1);
    repeat (9) @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    m_w = 0; m_s = 0; md_w = 1; md_s = 1;
    check("midrst_op_w", 32'(op_w), 0);
    check_state("midrst");
    rst = 1'b1;
    expect_step(cyc + 1 + LAT, 1'b1);
    repeat (10) @(posedge clk); #1;
    btn_up = 1'b0;
    repeat (14) @(posedge clk); #1;
    check_state("after_midrst");

`ifdef PB_AUTOREPEAT_EN
    // hold 50 cycles: first step, then every 5 cycles after a 20-cycle hold
    @(posedge clk); #1;
    btn_up = 1'b1;
    k = cyc + 1;
    expect_step(k + LAT, 1'b1);
    for (int r = 0; r < 6; r++) expect_step(k + LAT + 20 + 5 * r, 1'b1);
    repeat (50) @(posedge clk); #1;
    btn_up = 1'b0;
    repeat (16) @(posedge clk); #1;
    check_state("autorepeat");
`endif

    repeat (4) @(posedge clk); #1;
    check("pending_w", q_w.size(), 0);
    check("pending_s", q_s.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
